// File: rtl/matrix_addr_gen.sv
// Multi-lane address generator for the matrix-multiply datapath: emits LANES
// addresses per group of a row-major ROWS x COLS matrix, walked by rows or by columns.
module matrix_addr_gen #(
    parameter int LANES  = 8,
    parameter int ROWS   = 64,
    parameter int COLS   = 64,
    parameter int ADDR_W = 14
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic                    col_mode,
    input  logic                    enable,
    output logic [LANES*ADDR_W-1:0] addr,
    output logic                    valid,
    output logic                    busy,
    output logic                    done
);

    if ((64'd1 << ADDR_W) < (64'(ROWS) * 64'(COLS))) begin : g_addrWidthCheck
        $error("matrix_addr_gen: ADDR_W too small for ROWS*COLS");
    end
    if (((ROWS % LANES) != 0) || ((COLS % LANES) != 0)) begin : g_laneDivCheck
        $error("matrix_addr_gen: LANES must divide ROWS and COLS");
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [ADDR_W-1:0] LAST_ROW_ADDR = ADDR_W'(ROWS * COLS - LANES);
    localparam logic [ADDR_W-1:0] LAST_ROW0     = ADDR_W'(ROWS - LANES);
    localparam logic [ADDR_W-1:0] LAST_COL      = ADDR_W'(COLS - 1);
    localparam logic [ADDR_W-1:0] STEP_ROW      = ADDR_W'(LANES);
    localparam logic [ADDR_W-1:0] STEP_COL      = ADDR_W'(LANES * COLS);
    localparam logic [ADDR_W-1:0] ONE           = ADDR_W'(1);

    state_t            r_state;
    state_t            w_nextState;
    logic              r_colMode;
    logic [ADDR_W-1:0] r_row0;
    logic [ADDR_W-1:0] r_col;
    logic [ADDR_W-1:0] r_addr     [LANES];
    logic [ADDR_W-1:0] w_nextAddr [LANES];
    logic [ADDR_W-1:0] w_nextRow0;
    logic [ADDR_W-1:0] w_nextCol;
    logic              w_start;
    logic              w_consume;
    logic              w_lastGroup;

    assign w_start     = ((r_state == IDLE) || (r_state == DONE)) && start;
    assign w_consume   = (r_state == RUN) && enable;
    assign w_lastGroup = r_colMode ? ((r_row0 == LAST_ROW0) && (r_col == LAST_COL))
                                   : (r_addr[0] == LAST_ROW_ADDR);

    always_ff @(negedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        unique case (r_state)
            IDLE:    if (start) w_nextState = RUN;
            RUN:     if (enable && w_lastGroup) w_nextState = DONE;
            DONE:    if (start) w_nextState = RUN;
            default: w_nextState = IDLE;
        endcase
    end

    always_comb begin
        valid = (r_state == RUN);
        busy  = (r_state == RUN);
        done  = (r_state == DONE);
    end

    // Column walk steps down LANES rows at a time; at the bottom it wraps to
    // the top of the next column using the constant per-lane offset l*COLS.
    always_comb begin
        w_nextRow0 = r_row0;
        w_nextCol  = r_col;
        for (int l = 0; l < LANES; l++) begin
            w_nextAddr[l] = r_addr[l];
        end
        if (w_start) begin
            w_nextRow0 = '0;
            w_nextCol  = '0;
            for (int l = 0; l < LANES; l++) begin
                w_nextAddr[l] = col_mode ? ADDR_W'(l * COLS) : ADDR_W'(l);
            end
        end else if (w_consume && !w_lastGroup) begin
            if (!r_colMode) begin
                for (int l = 0; l < LANES; l++) begin
                    w_nextAddr[l] = r_addr[l] + STEP_ROW;
                end
            end else if (r_row0 != LAST_ROW0) begin
                w_nextRow0 = r_row0 + STEP_ROW;
                for (int l = 0; l < LANES; l++) begin
                    w_nextAddr[l] = r_addr[l] + STEP_COL;
                end
            end else begin
                w_nextRow0 = '0;
                w_nextCol  = r_col + ONE;
                for (int l = 0; l < LANES; l++) begin
                    w_nextAddr[l] = ADDR_W'(l * COLS) + r_col + ONE;
                end
            end
        end
    end

    always_ff @(negedge clk or negedge reset) begin
        if (!reset) begin
            r_colMode <= 1'b0;
            r_row0    <= '0;
            r_col     <= '0;
            for (int l = 0; l < LANES; l++) begin
                r_addr[l] <= ADDR_W'(l);
            end
        end else begin
            if (w_start) begin
                r_colMode <= col_mode;
            end
            r_row0 <= w_nextRow0;
            r_col  <= w_nextCol;
            for (int l = 0; l < LANES; l++) begin
                r_addr[l] <= w_nextAddr[l];
            end
        end
    end

    for (genvar g = 0; g < LANES; g++) begin : g_pack
        assign addr[g*ADDR_W +: ADDR_W] = r_addr[g];
    end

endmodule

// File: tb/tb_matrix_addr_gen.sv
// Scoreboard bench for matrix_addr_gen: a default 8x64x64 instance and a
// small 4-lane 8x16 instance, both checked against a divide-based address model.
module tb_matrix_addr_gen;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rstA, startA, colA, enA, validA, busyA, doneA;
    logic [111:0] addrA;
    logic         rstB, startB, colB, enB, validB, busyB, doneB;
    logic [27:0]  addrB;

    matrix_addr_gen dutA (
        .clk(clk), .reset(rstA), .start(startA), .col_mode(colA), .enable(enA),
        .addr(addrA), .valid(validA), .busy(busyA), .done(doneA)
    );

    matrix_addr_gen #(.LANES(4), .ROWS(8), .COLS(16), .ADDR_W(7)) dutB (
        .clk(clk), .reset(rstB), .start(startB), .col_mode(colB), .enable(enB),
        .addr(addrB), .valid(validB), .busy(busyB), .done(doneB)
    );

    typedef struct packed {
        logic [111:0] addr;
        logic         valid;
        logic         busy;
        logic         done;
    } rec_t;

    rec_t         sb[$];
    int           errors = 0;
    int           checks = 0;
    int           mState[2];
    int           mMode[2];
    int           mK[2];
    logic [111:0] mAddr[2];

    // Independent model: consume index k maps directly to a group with div/mod.
    function automatic logic [111:0] groupAddr(int dut, int mode, int k);
        int lanes, rows, cols, aw, rpg;
        logic [111:0] r;
        r = '0;
        if (dut == 0) begin lanes = 8; rows = 64; cols = 64; aw = 14; end
        else          begin lanes = 4; rows = 8;  cols = 16; aw = 7;  end
        rpg = rows / lanes;
        for (int l = 0; l < lanes; l++) begin
            int v;
            if (mode == 0) v = k * lanes + l;
            else           v = ((k % rpg) * lanes + l) * cols + (k / rpg);
            for (int b = 0; b < aw; b++) r[l*aw + b] = v[b];
        end
        return r;
    endfunction

    function automatic rec_t expectedRec(int dut);
        rec_t e;
        e.addr  = mAddr[dut];
        e.valid = (mState[dut] == 1);
        e.busy  = (mState[dut] == 1);
        e.done  = (mState[dut] == 2);
        return e;
    endfunction

    function automatic rec_t observedRec(int dut);
        rec_t o;
        if (dut == 0) begin
            o.addr = addrA; o.valid = validA; o.busy = busyA; o.done = doneA;
        end else begin
            o.addr = {84'b0, addrB}; o.valid = validB; o.busy = busyB; o.done = doneB;
        end
        return o;
    endfunction

    task automatic modelReset(input int dut);
        mState[dut] = 0;
        mMode[dut]  = 0;
        mK[dut]     = 0;
        mAddr[dut]  = groupAddr(dut, 0, 0);
    endtask

    task automatic checkOutput(input string tag, input int dut);
        rec_t o, e;
        o = observedRec(dut);
        e = sb.pop_front();
        checks++;
        assert (o.addr === e.addr) else begin
            errors++;
            $error("[TB] FAIL %s addr observed=%h expected=%h", tag, o.addr, e.addr);
        end
        checks++;
        assert (o.valid === e.valid) else begin
            errors++;
            $error("[TB] FAIL %s valid observed=%b expected=%b", tag, o.valid, e.valid);
        end
        checks++;
        assert (o.busy === e.busy) else begin
            errors++;
            $error("[TB] FAIL %s busy observed=%b expected=%b", tag, o.busy, e.busy);
        end
        checks++;
        assert (o.done === e.done) else begin
            errors++;
            $error("[TB] FAIL %s done observed=%b expected=%b", tag, o.done, e.done);
        end
    endtask

    task automatic checkLane(input string tag, input logic [13:0] observed, input logic [13:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    // Drives one falling edge of stimulus on one DUT (the other DUT idles),
    // pushes the model's post-edge expectation, then compares at the rising edge.
    task automatic applyStimulus(input int dut, input logic st, input logic cm,
                                 input logic en, input string tag);
        int total;
        total = (dut == 0) ? 512 : 32;
        if (dut == 0) begin
            startA = st; colA = cm; enA = en; startB = 1'b0; enB = 1'b0;
        end else begin
            startB = st; colB = cm; enB = en; startA = 1'b0; enA = 1'b0;
        end
        if ((mState[dut] != 1) && st) begin
            mState[dut] = 1;
            mMode[dut]  = int'(cm);
            mK[dut]     = 0;
            mAddr[dut]  = groupAddr(dut, mMode[dut], 0);
        end else if ((mState[dut] == 1) && en) begin
            if (mK[dut] == total - 1) begin
                mState[dut] = 2;
            end else begin
                mK[dut]++;
                mAddr[dut] = groupAddr(dut, mMode[dut], mK[dut]);
            end
        end
        sb.push_back(expectedRec(dut));
        @(negedge clk);
        @(posedge clk);
        checkOutput(tag, dut);
    endtask

    initial begin
        rstA = 1'b1; rstB = 1'b1;
        startA = 1'b0; colA = 1'b0; enA = 1'b0;
        startB = 1'b0; colB = 1'b0; enB = 1'b0;
        #1;
        rstA = 1'b0; rstB = 1'b0;
        #11;
        modelReset(0);
        modelReset(1);
        sb.push_back(expectedRec(0));
        checkOutput("resetA", 0);
        sb.push_back(expectedRec(1));
        checkOutput("resetB", 1);
        @(posedge clk);
        rstA = 1'b1; rstB = 1'b1;

        $display("[TB] row-major sweep");
        applyStimulus(0, 1'b1, 1'b0, 1'b1, "rowStart");
        for (int i = 0; i < 512; i++) applyStimulus(0, 1'b0, 1'b0, 1'b1, "rowSweep");
        checkLane("rowDoneLane0", addrA[13:0], 14'd4088);
        checkLane("rowDoneLane7", addrA[111:98], 14'd4095);
        applyStimulus(0, 1'b0, 1'b0, 1'b1, "rowDoneHold");
        applyStimulus(0, 1'b0, 1'b1, 1'b0, "rowDoneIdle");

        $display("[TB] column-major restart from DONE");
        applyStimulus(0, 1'b1, 1'b1, 1'b1, "colStart");
        checkLane("colG0Lane1", addrA[27:14], 14'd64);
        checkLane("colG0Lane7", addrA[111:98], 14'd448);
        for (int i = 0; i < 512; i++) begin
            applyStimulus(0, (i == 100), 1'b0, 1'b1, "colSweep");
            if (i == 7) checkLane("colG8Lane0", addrA[13:0], 14'd1);
        end
        checkLane("colLastLane0", addrA[13:0], 14'd3647);
        applyStimulus(0, 1'b0, 1'b0, 1'b1, "colDoneHold");

        $display("[TB] stall and async reset mid-sweep");
        applyStimulus(0, 1'b1, 1'b0, 1'b1, "rowStart2");
        applyStimulus(0, 1'b0, 1'b0, 1'b1, "toGroup8");
        applyStimulus(0, 1'b0, 1'b0, 1'b1, "toGroup16");
        for (int i = 0; i < 5; i++) applyStimulus(0, 1'b0, 1'b0, 1'b0, "stall");
        applyStimulus(0, 1'b0, 1'b0, 1'b1, "afterStall");
        checkLane("afterStallLane0", addrA[13:0], 14'd24);
        for (int i = 0; i < 22; i++) applyStimulus(0, 1'b0, 1'b0, 1'b1, "toGroup200");
        #2;
        rstA = 1'b0;
        #1;
        modelReset(0);
        sb.push_back(expectedRec(0));
        checkOutput("midReset", 0);
        #1;
        rstA = 1'b1;
        applyStimulus(0, 1'b1, 1'b0, 1'b1, "startAfterReset");
        applyStimulus(0, 1'b0, 1'b0, 1'b1, "runAfterReset");

        $display("[TB] small instance column sweep");
        applyStimulus(1, 1'b1, 1'b1, 1'b1, "smallStart");
        for (int i = 0; i < 32; i++) applyStimulus(1, 1'b0, 1'b1, 1'b1, "smallSweep");
        applyStimulus(1, 1'b0, 1'b0, 1'b1, "smallDoneHold");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
